fetch_ctrl: RTL

- Instruction-fetch sequencer for the 5-stage pipelined RV32I core.
- Owns the PC and issues one-at-a-time requests to the instruction memory.
- Accepts responses, loads the IF/ID pipeline register, and keeps one word in a skid entry while ID is stalled.
- Services branch/jump redirects from EX, dropping any in-flight stale fetch.

---
 rtl/rv_core_pkg.sv | 33 +++
 rtl/fetch_skid.sv | 43 ++++
 rtl/fetch_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/rv_core_pkg.sv
// Shared types and constants for the RV32I core front end.
package rv_core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RV_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    StBoot,
    StIssue,
    StWait,
    StDrain,
    StHold
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;

  // Bubble keeps the previous pc; only valid/instr carry meaning.
  function automatic if_id_t make_bubble(input logic [XLEN-1:0] pc,
                                         input logic [XLEN-1:0] nop);
    if_id_t b;
    b.valid = 1'b0;
    b.instr = nop;
    b.pc    = pc;
    return b;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
module fetch_skid
  import rv_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            unload,
  input  logic            flush,
  input  logic [XLEN-1:0] ld_instr,
  input  logic [XLEN-1:0] ld_pc,
  output logic            full,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  logic            full_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      if (flush || unload) begin
        full_q <= 1'b0;
      end else if (load) begin
        full_q <= 1'b1;
      end
      if (load && !flush) begin
        instr_q <= ld_instr;
        pc_q    <= ld_pc;
      end
    end
  end

  assign full  = full_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single outstanding imem requests,
// fills IF/ID, parks one word in a skid entry under stall and services EX redirects.
module fetch_ctrl
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RV_RESET_PC,
  parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  if_id_t       if_id_q, if_id_d;

  logic        skid_load, skid_unload, skid_flush, skid_full;
  logic [31:0] skid_instr, skid_pc;

  fetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .unload   (skid_unload),
    .flush    (skid_flush),
    .ld_instr (imem_rdata),
    .ld_pc    (pc_q),
    .full     (skid_full),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      if_id_q <= make_bubble(32'h0, NOP_INSTR);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_id_d     = if_id_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;

    if (redirect_i) begin
      pc_d       = redirect_pc_i & 32'hFFFF_FFFC;
      if_id_d    = make_bubble(if_id_q.pc, NOP_INSTR);
      skid_flush = 1'b1;
      unique case (state_q)
        // A response arriving now retires the outstanding request; otherwise drain it.
        StIssue, StWait, StDrain: state_d = imem_rvalid ? StIssue : StDrain;
        default:                  state_d = StIssue;
      endcase
    end else begin
      unique case (state_q)
        StBoot: begin
          state_d = StIssue;
          if (!stall_i) if_id_d = make_bubble(if_id_q.pc, NOP_INSTR);
        end
        StIssue, StWait: begin
          if (imem_rvalid) begin
            pc_d    = pc_q + 32'd4;
            state_d = StIssue;
            if (!stall_i || !if_id_q.valid) begin
              if_id_d.valid = 1'b1;
              if_id_d.instr = imem_rdata;
              if_id_d.pc    = pc_q;
            end else begin
              skid_load = 1'b1;
              state_d   = StHold;
            end
          end else begin
            state_d = StWait;
            if (!stall_i) if_id_d = make_bubble(if_id_q.pc, NOP_INSTR);
          end
        end
        StHold: begin
          if (!stall_i && skid_full) begin
            if_id_d.valid = 1'b1;
            if_id_d.instr = skid_instr;
            if_id_d.pc    = skid_pc;
            skid_unload   = 1'b1;
            state_d       = StIssue;
          end
        end
        StDrain: begin
          if (imem_rvalid) state_d = StIssue;
          if (!stall_i) if_id_d = make_bubble(if_id_q.pc, NOP_INSTR);
        end
        default: state_d = StBoot;
      endcase
    end
  end

  assign imem_req    = (state_q == StIssue);
  assign imem_addr   = pc_q;
  assign if_id_valid = if_id_q.valid;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc    = if_id_q.pc;

endmodule
